connect_n_engine: RTL and testbench

- Parametrised drop-piece game engine (Connect-N) for the score4 family; generalises the fixed 6x7, 2-player, 4-in-a-row core.
- Configurable board size, win length and player count.
- Incremental multi-cycle win check around the last placed piece.
- Synchronous new-game restart and a cell read port for the VGA renderer; the engine contains no VGA timing.

---
 rtl/connect_n_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_connect_n_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect_n_engine.sv
// connect_n_engine: parametrised Connect-N drop-piece game engine.
//
// The board is ROWS x COLS (row 0 is the top row, column 0 the leftmost).
// Players take turns dropping pieces into the cursor column. After each
// drop the engine spends four cycles checking the four line directions
// through the new piece. It only looks at the last move and never scans
// the whole board.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   left, right   - level inputs; a rising edge moves the cursor
//   put           - level input; a rising edge drops a piece
//   new_game      - synchronous restart, highest priority in any state
//   rd_row/rd_col - renderer read address
//   rd_cell       - combinational cell value (0 empty, p+1 for player p)
//   cursor_col    - current drop column
//   player        - player to move
//   busy          - high while checking or when the game is over
//   invalid_move  - one-cycle pulse for each rejected action
//   win/winner    - sticky win flag and the winning player
//   full_panel    - sticky draw flag
//   move_count    - number of pieces placed
module connect_n_engine #(
    parameter int ROWS     = 6,
    parameter int COLS     = 7,
    parameter int WIN_LEN  = 4,
    parameter int NPLAYERS = 2,
    localparam int CW = $clog2(NPLAYERS + 1),
    localparam int PW = $clog2(NPLAYERS),
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS),
    localparam int MW = $clog2(ROWS * COLS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          left,
    input  logic          right,
    input  logic          put,
    input  logic          new_game,
    input  logic [YW-1:0] rd_row,
    input  logic [XW-1:0] rd_col,
    output logic [CW-1:0] rd_cell,
    output logic [XW-1:0] cursor_col,
    output logic [PW-1:0] player,
    output logic          busy,
    output logic          invalid_move,
    output logic          win,
    output logic [PW-1:0] winner,
    output logic          full_panel,
    output logic [MW-1:0] move_count
);

    localparam int HW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

    state_t        state_q;
    logic [CW-1:0] cells_q [ROWS][COLS];
    logic [HW-1:0] heights_q [COLS];
    logic [XW-1:0] cursor_q;
    logic [PW-1:0] player_q;
    logic [MW-1:0] moves_q;
    logic [YW-1:0] lastRow_q;
    logic [XW-1:0] lastCol_q;
    logic [1:0]    dir_q;
    logic          hit_q;
    logic          win_q;
    logic [PW-1:0] winner_q;
    logic          full_q;
    logic          invalid_q;
    logic          leftPrev_q;
    logic          rightPrev_q;
    logic          putPrev_q;

    logic          leftEdge;
    logic          rightEdge;
    logic          putEdge;
    logic [CW-1:0] colour;
    logic [YW-1:0] dropRow;
    logic          columnFull;
    logic          lineFound;

    int dr, dc, rPos, cPos, rNeg, cNeg, cntPos, cntNeg;
    logic runPos, runNeg;

    function automatic logic inBoard(int r, int c);
        return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
    endfunction

    assign leftEdge   = left & ~leftPrev_q;
    assign rightEdge  = right & ~rightPrev_q;
    assign putEdge    = put & ~putPrev_q;
    assign colour     = CW'(player_q) + CW'(1);
    assign columnFull = (int'(heights_q[cursor_q]) == ROWS);
    // Pieces stack from the bottom row upwards.
    assign dropRow    = YW'(ROWS - 1 - int'(heights_q[cursor_q]));

    // Walk outwards from the last piece in both senses of the current
    // direction. The walk stops at the first foreign cell or at the board
    // edge. The loop bound caps each run at WIN_LEN-1.
    always_comb begin
        case (dir_q)
            2'd0:    begin dr = 0;  dc = 1; end
            2'd1:    begin dr = 1;  dc = 0; end
            2'd2:    begin dr = -1; dc = 1; end
            default: begin dr = 1;  dc = 1; end
        endcase
        cntPos = 0;
        cntNeg = 0;
        runPos = 1'b1;
        runNeg = 1'b1;
        rPos   = 0;
        cPos   = 0;
        rNeg   = 0;
        cNeg   = 0;
        for (int k = 1; k < WIN_LEN; k++) begin
            rPos = int'(lastRow_q) + k * dr;
            cPos = int'(lastCol_q) + k * dc;
            rNeg = int'(lastRow_q) - k * dr;
            cNeg = int'(lastCol_q) - k * dc;
            if (runPos && inBoard(rPos, cPos) &&
                cells_q[rPos[YW-1:0]][cPos[XW-1:0]] == colour)
                cntPos = cntPos + 1;
            else
                runPos = 1'b0;
            if (runNeg && inBoard(rNeg, cNeg) &&
                cells_q[rNeg[YW-1:0]][cNeg[XW-1:0]] == colour)
                cntNeg = cntNeg + 1;
            else
                runNeg = 1'b0;
        end
        lineFound = (1 + cntPos + cntNeg) >= WIN_LEN;
    end

    // Main game FSM. The edge-detect registers keep tracking their inputs
    // through new_game, so a button held across a restart does not fire again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells_q[r][c] <= '0;
            for (int c = 0; c < COLS; c++)
                heights_q[c] <= '0;
            state_q     <= IDLE;
            cursor_q    <= '0;
            player_q    <= '0;
            moves_q     <= '0;
            lastRow_q   <= '0;
            lastCol_q   <= '0;
            dir_q       <= '0;
            hit_q       <= 1'b0;
            win_q       <= 1'b0;
            winner_q    <= '0;
            full_q      <= 1'b0;
            invalid_q   <= 1'b0;
            leftPrev_q  <= 1'b0;
            rightPrev_q <= 1'b0;
            putPrev_q   <= 1'b0;
        end else begin
            leftPrev_q  <= left;
            rightPrev_q <= right;
            putPrev_q   <= put;
            invalid_q   <= 1'b0;
            if (new_game) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        cells_q[r][c] <= '0;
                for (int c = 0; c < COLS; c++)
                    heights_q[c] <= '0;
                state_q   <= IDLE;
                cursor_q  <= '0;
                player_q  <= '0;
                moves_q   <= '0;
                lastRow_q <= '0;
                lastCol_q <= '0;
                dir_q     <= '0;
                hit_q     <= 1'b0;
                win_q     <= 1'b0;
                winner_q  <= '0;
                full_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rightEdge) begin
                            if (cursor_q == XW'(COLS - 1))
                                invalid_q <= 1'b1;
                            else
                                cursor_q <= cursor_q + 1'b1;
                        end else if (leftEdge) begin
                            if (cursor_q == '0)
                                invalid_q <= 1'b1;
                            else
                                cursor_q <= cursor_q - 1'b1;
                        end else if (putEdge) begin
                            if (columnFull) begin
                                invalid_q <= 1'b1;
                            end else begin
                                cells_q[dropRow][cursor_q] <= colour;
                                heights_q[cursor_q] <= heights_q[cursor_q] + 1'b1;
                                moves_q   <= moves_q + 1'b1;
                                lastRow_q <= dropRow;
                                lastCol_q <= cursor_q;
                                dir_q     <= 2'd0;
                                hit_q     <= 1'b0;
                                state_q   <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        hit_q <= hit_q | lineFound;
                        dir_q <= dir_q + 2'd1;
                        if (dir_q == 2'd3) begin
                            if (hit_q | lineFound) begin
                                win_q    <= 1'b1;
                                winner_q <= player_q;
                                state_q  <= OVER;
                            end else if (moves_q == MW'(ROWS * COLS)) begin
                                full_q  <= 1'b1;
                                state_q <= OVER;
                            end else begin
                                player_q <= (player_q == PW'(NPLAYERS - 1)) ? '0 : player_q + 1'b1;
                                state_q  <= IDLE;
                            end
                        end
                    end
                    OVER: begin
                        if (leftEdge | rightEdge | putEdge)
                            invalid_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rd_cell      = (int'(rd_row) < ROWS && int'(rd_col) < COLS) ? cells_q[rd_row][rd_col] : '0;
    assign cursor_col   = cursor_q;
    assign player       = player_q;
    assign busy         = (state_q != IDLE);
    assign invalid_move = invalid_q;
    assign win          = win_q;
    assign winner       = winner_q;
    assign full_panel   = full_q;
    assign move_count   = moves_q;

endmodule

// File: tb/tb_connect_n_engine.sv
// Testbench for connect_n_engine. Three instances cover three configurations:
// dut0 uses the defaults (6x7, 4 in a row, 2 players), dut1 is a 2x4 board
// with 3 in a row, and dut2 has 3 players. Stimulus pushes expected values
// into a queue. A negedge monitor pops them and compares them against the
// DUT outputs. It also counts invalid_move pulses per instance.
module tb_connect_n_engine;

    localparam int F_CURSOR = 0;
    localparam int F_PLAYER = 1;
    localparam int F_BUSY   = 2;
    localparam int F_WIN    = 3;
    localparam int F_WINNER = 4;
    localparam int F_FULL   = 5;
    localparam int F_MOVES  = 6;
    localparam int F_CELL   = 7;
    localparam int F_IMV    = 8;
    localparam int F_PULSES = 9;

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_PUT   = 2;
    localparam int K_NEW   = 3;

    typedef struct {
        string name;
        int    d;
        int    f;
        int    v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic leftIn [3];
    logic rightIn [3];
    logic putIn [3];
    logic newIn [3];

    logic [2:0] rdRow0, rdCol0, rdRow2, rdCol2;
    logic       rdRow1;
    logic [1:0] rdCol1;

    logic [1:0] cell0, cell1, cell2;
    logic [2:0] cur0, cur2;
    logic [1:0] cur1;
    logic       ply0, ply1, win0, win1, wnr0, wnr1;
    logic [1:0] ply2, wnr2;
    logic       busy0, busy1, busy2, imv0, imv1, imv2, win2, full0, full1, full2;
    logic [5:0] mv0, mv2;
    logic [3:0] mv1;

    int   obs [3][9];
    int   pulses [3] = '{0, 0, 0};
    int   curCol [3] = '{0, 0, 0};
    exp_t expQ [$];
    int   checks = 0;
    int   errors = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    connect_n_engine dut0 (
        .clk(clk), .rst(rst), .left(leftIn[0]), .right(rightIn[0]), .put(putIn[0]),
        .new_game(newIn[0]), .rd_row(rdRow0), .rd_col(rdCol0), .rd_cell(cell0),
        .cursor_col(cur0), .player(ply0), .busy(busy0), .invalid_move(imv0),
        .win(win0), .winner(wnr0), .full_panel(full0), .move_count(mv0)
    );

    connect_n_engine #(.ROWS(2), .COLS(4), .WIN_LEN(3), .NPLAYERS(2)) dut1 (
        .clk(clk), .rst(rst), .left(leftIn[1]), .right(rightIn[1]), .put(putIn[1]),
        .new_game(newIn[1]), .rd_row(rdRow1), .rd_col(rdCol1), .rd_cell(cell1),
        .cursor_col(cur1), .player(ply1), .busy(busy1), .invalid_move(imv1),
        .win(win1), .winner(wnr1), .full_panel(full1), .move_count(mv1)
    );

    connect_n_engine #(.NPLAYERS(3)) dut2 (
        .clk(clk), .rst(rst), .left(leftIn[2]), .right(rightIn[2]), .put(putIn[2]),
        .new_game(newIn[2]), .rd_row(rdRow2), .rd_col(rdCol2), .rd_cell(cell2),
        .cursor_col(cur2), .player(ply2), .busy(busy2), .invalid_move(imv2),
        .win(win2), .winner(wnr2), .full_panel(full2), .move_count(mv2)
    );

    // Gather every observable output into one table indexed by instance and field.
    always_comb begin
        obs[0][F_CURSOR] = int'(cur0);  obs[1][F_CURSOR] = int'(cur1);  obs[2][F_CURSOR] = int'(cur2);
        obs[0][F_PLAYER] = int'(ply0);  obs[1][F_PLAYER] = int'(ply1);  obs[2][F_PLAYER] = int'(ply2);
        obs[0][F_BUSY]   = int'(busy0); obs[1][F_BUSY]   = int'(busy1); obs[2][F_BUSY]   = int'(busy2);
        obs[0][F_WIN]    = int'(win0);  obs[1][F_WIN]    = int'(win1);  obs[2][F_WIN]    = int'(win2);
        obs[0][F_WINNER] = int'(wnr0);  obs[1][F_WINNER] = int'(wnr1);  obs[2][F_WINNER] = int'(wnr2);
        obs[0][F_FULL]   = int'(full0); obs[1][F_FULL]   = int'(full1); obs[2][F_FULL]   = int'(full2);
        obs[0][F_MOVES]  = int'(mv0);   obs[1][F_MOVES]  = int'(mv1);   obs[2][F_MOVES]  = int'(mv2);
        obs[0][F_CELL]   = int'(cell0); obs[1][F_CELL]   = int'(cell1); obs[2][F_CELL]   = int'(cell2);
        obs[0][F_IMV]    = int'(imv0);  obs[1][F_IMV]    = int'(imv1);  obs[2][F_IMV]    = int'(imv2);
    end

    task automatic checkOutput(input exp_t e);
        int actual;
        actual = (e.f == F_PULSES) ? pulses[e.d] : obs[e.d][e.f];
        checks = checks + 1;
        if (actual !== e.v) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: dut%0d got %0d, expected %0d", e.name, e.d, actual, e.v);
        end
    endtask

    // Monitor: count invalid_move pulses, then drain pending expectations.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++)
            if (obs[d][F_IMV] != 0) pulses[d] = pulses[d] + 1;
        while (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Watchdog: the run is made of fixed cycle counts, but never let it hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic expectVal(input string name, input int d, input int f, input int v);
        exp_t e;
        e.name = name;
        e.d    = d;
        e.f    = f;
        e.v    = v;
        expQ.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setKey(input int d, input int key, input logic val);
        case (key)
            K_LEFT:  leftIn[d]  = val;
            K_RIGHT: rightIn[d] = val;
            K_PUT:   putIn[d]   = val;
            default: newIn[d]   = val;
        endcase
    endtask

    task automatic setRead(input int d, input int r, input int c);
        case (d)
            0:       begin rdRow0 = 3'(r); rdCol0 = 3'(c); end
            1:       begin rdRow1 = 1'(r); rdCol1 = 2'(c); end
            default: begin rdRow2 = 3'(r); rdCol2 = 3'(c); end
        endcase
    endtask

    // One clean rising edge on a single input: high for a cycle, then low for a cycle.
    task automatic applyStimulus(input int d, input int key);
        setKey(d, key, 1'b1);
        tick(1);
        setKey(d, key, 1'b0);
        tick(1);
    endtask

    // Move the cursor to col, drop a piece and wait out the check.
    task automatic dropAt(input int d, input int col);
        while (curCol[d] < col) begin
            applyStimulus(d, K_RIGHT);
            curCol[d] = curCol[d] + 1;
        end
        while (curCol[d] > col) begin
            applyStimulus(d, K_LEFT);
            curCol[d] = curCol[d] - 1;
        end
        applyStimulus(d, K_PUT);
        tick(5);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        for (int d = 0; d < 3; d++) curCol[d] = 0;
    endtask

    // Directed scenario sequence.
    initial begin
        for (int d = 0; d < 3; d++) begin
            leftIn[d] = 1'b0; rightIn[d] = 1'b0; putIn[d] = 1'b0; newIn[d] = 1'b0;
        end
        setRead(0, 5, 0);
        setRead(1, 1, 0);
        setRead(2, 5, 0);
        doReset();

        // Reset state.
        expectVal("rst_cursor", 0, F_CURSOR, 0);
        expectVal("rst_player", 0, F_PLAYER, 0);
        expectVal("rst_busy", 0, F_BUSY, 0);
        expectVal("rst_win", 0, F_WIN, 0);
        expectVal("rst_full", 0, F_FULL, 0);
        expectVal("rst_moves", 0, F_MOVES, 0);
        expectVal("rst_cell", 0, F_CELL, 0);
        tick(1);

        // Cursor limits.
        for (int i = 0; i < 6; i++) applyStimulus(0, K_RIGHT);
        expectVal("cursor_right_edge", 0, F_CURSOR, 6);
        expectVal("no_pulse_in_range", 0, F_PULSES, 0);
        applyStimulus(0, K_RIGHT);
        expectVal("cursor_hold_right", 0, F_CURSOR, 6);
        expectVal("pulse_right_edge", 0, F_PULSES, 1);
        tick(1);
        doReset();
        applyStimulus(0, K_LEFT);
        tick(1);
        expectVal("cursor_hold_left", 0, F_CURSOR, 0);
        expectVal("pulse_left_edge", 0, F_PULSES, 2);
        tick(1);

        // Vertical win for P0 in column 0.
        for (int i = 0; i < 7; i++) dropAt(0, i % 2);
        expectVal("vert_win", 0, F_WIN, 1);
        expectVal("vert_winner", 0, F_WINNER, 0);
        expectVal("vert_moves", 0, F_MOVES, 7);
        expectVal("vert_busy_over", 0, F_BUSY, 1);
        setRead(0, 5, 1);
        expectVal("vert_cell_p1", 0, F_CELL, 2);
        tick(1);
        applyStimulus(0, K_PUT);
        tick(1);
        expectVal("over_put_pulse", 0, F_PULSES, 3);
        expectVal("over_moves_frozen", 0, F_MOVES, 7);
        tick(1);

        // new_game clears everything.
        applyStimulus(0, K_NEW);
        curCol[0] = 0;
        setRead(0, 5, 0);
        expectVal("ng_moves", 0, F_MOVES, 0);
        expectVal("ng_win", 0, F_WIN, 0);
        expectVal("ng_busy", 0, F_BUSY, 0);
        expectVal("ng_cell", 0, F_CELL, 0);
        tick(1);

        // Fill column 3 with alternating players, then overflow it.
        for (int i = 0; i < 6; i++) dropAt(0, 3);
        expectVal("col_moves", 0, F_MOVES, 6);
        expectVal("col_no_win", 0, F_WIN, 0);
        setRead(0, 0, 3);
        expectVal("col_top_cell", 0, F_CELL, 2);
        tick(1);
        applyStimulus(0, K_PUT);
        tick(1);
        expectVal("col_full_pulse", 0, F_PULSES, 4);
        expectVal("col_full_moves", 0, F_MOVES, 6);
        expectVal("col_full_player", 0, F_PLAYER, 0);
        expectVal("col_full_idle", 0, F_BUSY, 0);
        tick(1);

        // Rising diagonal for P1, with an extra put dropped while checking.
        applyStimulus(0, K_NEW);
        curCol[0] = 0;
        dropAt(0, 2); dropAt(0, 1); dropAt(0, 3); dropAt(0, 2);
        dropAt(0, 3); dropAt(0, 6); dropAt(0, 4); dropAt(0, 3);
        dropAt(0, 4); dropAt(0, 6);
        while (curCol[0] > 4) begin
            applyStimulus(0, K_LEFT);
            curCol[0] = curCol[0] - 1;
        end
        applyStimulus(0, K_PUT);
        applyStimulus(0, K_PUT);
        tick(5);
        expectVal("check_put_ignored_moves", 0, F_MOVES, 11);
        expectVal("check_put_no_pulse", 0, F_PULSES, 4);
        expectVal("diag_pre_no_win", 0, F_WIN, 0);
        tick(1);
        dropAt(0, 4);
        expectVal("diag_win", 0, F_WIN, 1);
        expectVal("diag_winner", 0, F_WINNER, 1);
        expectVal("diag_moves", 0, F_MOVES, 12);
        setRead(0, 2, 4);
        expectVal("diag_cell", 0, F_CELL, 2);
        tick(1);

        // Small board draw on dut1.
        for (int i = 0; i < 8; i++) dropAt(1, i % 4);
        expectVal("draw_full", 1, F_FULL, 1);
        expectVal("draw_no_win", 1, F_WIN, 0);
        expectVal("draw_busy", 1, F_BUSY, 1);
        expectVal("draw_moves", 1, F_MOVES, 8);
        setRead(1, 0, 3);
        expectVal("draw_cell_top", 1, F_CELL, 2);
        tick(1);
        applyStimulus(1, K_PUT);
        tick(1);
        expectVal("draw_over_pulse", 1, F_PULSES, 1);
        expectVal("draw_over_moves", 1, F_MOVES, 8);
        tick(1);

        // Three players on dut2: right beats left when both rise together.
        setKey(2, K_LEFT, 1'b1);
        setKey(2, K_RIGHT, 1'b1);
        tick(1);
        setKey(2, K_LEFT, 1'b0);
        setKey(2, K_RIGHT, 1'b0);
        tick(1);
        curCol[2] = 1;
        expectVal("prio_cursor", 2, F_CURSOR, 1);
        expectVal("prio_no_pulse", 2, F_PULSES, 0);
        tick(1);
        dropAt(2, 0);
        expectVal("p3_player1", 2, F_PLAYER, 1);
        setRead(2, 5, 0);
        expectVal("p3_cell1", 2, F_CELL, 1);
        dropAt(2, 1);
        expectVal("p3_player2", 2, F_PLAYER, 2);
        setRead(2, 5, 1);
        expectVal("p3_cell2", 2, F_CELL, 2);
        dropAt(2, 2);
        expectVal("p3_player_wrap", 2, F_PLAYER, 0);
        setRead(2, 5, 2);
        expectVal("p3_cell3", 2, F_CELL, 3);
        tick(1);

        // new_game asserted during CHECK of a fourth put.
        applyStimulus(2, K_RIGHT);
        setKey(2, K_PUT, 1'b1);
        tick(1);
        setKey(2, K_PUT, 1'b0);
        setKey(2, K_NEW, 1'b1);
        tick(1);
        setKey(2, K_NEW, 1'b0);
        setRead(2, 5, 0);
        expectVal("ng_check_moves", 2, F_MOVES, 0);
        expectVal("ng_check_busy", 2, F_BUSY, 0);
        expectVal("ng_check_cell", 2, F_CELL, 0);
        expectVal("ng_check_player", 2, F_PLAYER, 0);
        expectVal("ng_check_cursor", 2, F_CURSOR, 0);
        tick(1);
        setRead(2, 5, 3);
        expectVal("ng_check_cell_new", 2, F_CELL, 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
